// File: rtl/intc_ctrl.sv
// Six-source interrupt controller: per-source mask and edge/level mode,
// lowest-index-wins selection, and a request/ack/EOI handshake with the CPU.
module intc_ctrl #(
  parameter int unsigned      NSRC     = 6,
  parameter logic [NSRC-1:0]  MASK_RST = '0,
  parameter logic [NSRC-1:0]  MODE_RST = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we,
  input  logic [2:0]      addr,
  input  logic [31:0]     wd,
  output logic [31:0]     rd,
  input  logic [NSRC-1:0] src,
  input  logic            ack,
  output logic            irq
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t          state, stateNext;
  logic [2:0]      id, idNext;
  logic [NSRC-1:0] maskReg, modeReg, edgePend, srcQ;
  logic [NSRC-1:0] pend, eligible, idOh, edgeSet, edgeClr, edgeNext, modeNext;
  logic [2:0]      topId;
  logic            found, eligId;
  logic            wrMask, wrPend, wrMode, wrEoi;
  logic            unusedWdBits;

  // Only the low NSRC bits of a write carry register content.
  assign unusedWdBits = ^wd[31:NSRC];

  assign wrMask = we && (addr == 3'd0);
  assign wrPend = we && (addr == 3'd1);
  assign wrMode = we && (addr == 3'd2);
  assign wrEoi  = we && (addr == 3'd4);

  assign pend     = (modeReg & edgePend) | (~modeReg & src);
  assign eligible = pend & maskReg;
  assign modeNext = wrMode ? wd[NSRC-1:0] : modeReg;
  assign edgeSet  = modeReg & src & ~srcQ;
  assign edgeClr  = (wrPend ? wd[NSRC-1:0] : '0) |
                    ((state == REQ && ack) ? idOh : '0);
  // Set beats clear; a source switched to level drops its stored edge bit.
  assign edgeNext = ((edgePend & ~edgeClr) | edgeSet) & modeNext;

  always_comb begin
    idOh   = '0;
    topId  = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      idOh[i] = (id == 3'(i));
      if (eligible[i] && !found) begin
        topId = 3'(i);
        found = 1'b1;
      end
    end
    eligId = |(eligible & idOh);
  end

  always_comb begin
    stateNext = state;
    idNext    = id;
    case (state)
      IDLE: begin
        if (found) begin
          stateNext = REQ;
          idNext    = topId;
        end
      end
      REQ: begin
        if (ack)          stateNext = SERVICE;
        else if (!eligId) stateNext = IDLE;
      end
      SERVICE: begin
        if (wrEoi) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      id       <= '0;
      irq      <= 1'b0;
      maskReg  <= MASK_RST;
      modeReg  <= MODE_RST;
      edgePend <= '0;
      srcQ     <= '0;
    end else begin
      state    <= stateNext;
      id       <= idNext;
      irq      <= (stateNext == REQ);
      if (wrMask) maskReg <= wd[NSRC-1:0];
      modeReg  <= modeNext;
      edgePend <= edgeNext;
      srcQ     <= src;
    end
  end

  always_comb begin
    rd = '0;
    case (addr)
      3'd0:    rd = {{(32-NSRC){1'b0}}, maskReg};
      3'd1:    rd = {{(32-NSRC){1'b0}}, pend};
      3'd2:    rd = {{(32-NSRC){1'b0}}, modeReg};
      3'd3:    rd = {26'b0, state, 1'b0, id};
      default: rd = '0;
    endcase
  end

endmodule

// File: tb/tb_intc_ctrl.sv
// Bench for intc_ctrl: directed vector table, async-reset corner, and a
// randomized run against a rule-level reference model.
module tb_intc_ctrl;

  localparam int NSRC = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [2:0]  addr;
  logic [31:0] wd;
  logic [31:0] rd;
  logic [5:0]  src;
  logic        ack;
  logic        irq;

  int nTests = 0;
  int nFail  = 0;

  intc_ctrl #(.NSRC(6), .MASK_RST(6'b000000), .MODE_RST(6'b000000)) dut (
    .clk(clk), .reset(reset), .we(we), .addr(addr), .wd(wd), .rd(rd),
    .src(src), .ack(ack), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  wa;
    logic [31:0] wd;
    logic [5:0]  src;
    logic        ack;
    logic [2:0]  ra;
    logic [31:0] expRd;
    logic        expIrq;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic w, input logic [2:0] wa, input logic [31:0] d,
                              input logic [5:0] s, input logic k, input logic [2:0] ra,
                              input logic [31:0] er, input logic ei);
    vec_t v;
    v.we = w; v.wa = wa; v.wd = d; v.src = s; v.ack = k;
    v.ra = ra; v.expRd = er; v.expIrq = ei;
    return v;
  endfunction

  task automatic applyVec(input int n, input vec_t v);
    @(negedge clk);
    we = v.we; addr = v.wa; wd = v.wd; src = v.src; ack = v.ack;
    @(posedge clk);
    #1;
    we = 1'b0; ack = 1'b0; addr = v.ra;
    #1;
    chk($sformatf("vec%0d.rd", n), rd, v.expRd);
    chk($sformatf("vec%0d.irq", n), {31'b0, irq}, {31'b0, v.expIrq});
  endtask

  // Reference model: per-source arrays, rules applied directly.
  bit mMask[NSRC], mMode[NSRC], mEdge[NSRC], mPrev[NSRC];
  int mState, mId;
  bit mIrq;

  function automatic bit mPend(input int i, input logic [5:0] s);
    return mMode[i] ? mEdge[i] : s[i];
  endfunction

  function automatic logic [31:0] mRead(input int a, input logic [5:0] s);
    logic [31:0] r = 0;
    for (int i = 0; i < NSRC; i++) begin
      if (a == 0) r[i] = mMask[i];
      if (a == 1) r[i] = mPend(i, s);
      if (a == 2) r[i] = mMode[i];
    end
    if (a == 3) r = mState * 16 + mId;
    return r;
  endfunction

  task automatic mReset();
    for (int i = 0; i < NSRC; i++) begin
      mMask[i] = 0; mMode[i] = 0; mEdge[i] = 0; mPrev[i] = 0;
    end
    mState = 0; mId = 0; mIrq = 0;
  endtask

  task automatic mStep(input bit w, input int a, input logic [31:0] d,
                       input logic [5:0] s, input bit k);
    bit elig[NSRC];
    bit nEdge[NSRC];
    int best = -1;
    for (int i = 0; i < NSRC; i++) begin
      elig[i] = mPend(i, s) && mMask[i];
      if (elig[i] && best < 0) best = i;
    end
    for (int i = 0; i < NSRC; i++) begin
      bit rise = mMode[i] && s[i] && !mPrev[i];
      bit clr  = (w && a == 1 && d[i]) || (mState == 1 && k && mId == i);
      nEdge[i] = rise ? 1'b1 : (clr ? 1'b0 : mEdge[i]);
    end
    if (mState == 0) begin
      if (best >= 0) begin mState = 1; mId = best; end
    end else if (mState == 1) begin
      if (k) mState = 2;
      else if (!elig[mId]) mState = 0;
    end else if (w && a == 4) begin
      mState = 0;
    end
    for (int i = 0; i < NSRC; i++) begin
      if (w && a == 0) mMask[i] = d[i];
      if (w && a == 2) mMode[i] = d[i];
      mEdge[i] = nEdge[i] && mMode[i];
      mPrev[i] = s[i];
    end
    mIrq = (mState == 1);
  endtask

  initial begin
    // Reset with all sources high
    reset = 1'b0; we = 1'b0; addr = 3'd0; wd = '0; src = 6'h3F; ack = 1'b0;
    #3;
    chk("rst.irq", {31'b0, irq}, 32'd0);
    chk("rst.mask", rd, 32'd0);
    addr = 3'd2; #1 chk("rst.mode", rd, 32'd0);
    addr = 3'd3; #1 chk("rst.status", rd, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("rstRel%0d.irq", c), {31'b0, irq}, 32'd0);
    end

    // Level single source
    vecs.push_back(mk(1, 0, 32'h04, 6'h00, 0, 0, 32'h04, 0));
    vecs.push_back(mk(0, 0, 32'h00, 6'h04, 0, 3, 32'h12, 1));
    vecs.push_back(mk(0, 0, 32'h00, 6'h04, 1, 3, 32'h22, 0));
    vecs.push_back(mk(0, 0, 32'h00, 6'h04, 0, 3, 32'h22, 0));
    vecs.push_back(mk(1, 4, 32'h00, 6'h04, 0, 3, 32'h02, 0));
    vecs.push_back(mk(0, 0, 32'h00, 6'h04, 0, 3, 32'h12, 1));
    vecs.push_back(mk(0, 0, 32'h00, 6'h04, 1, 3, 32'h22, 0));
    vecs.push_back(mk(1, 4, 32'h00, 6'h00, 0, 3, 32'h02, 0));
    vecs.push_back(mk(0, 0, 32'h00, 6'h00, 0, 1, 32'h00, 0));
    // Edge mode, priority
    vecs.push_back(mk(1, 2, 32'h3F, 6'h00, 0, 2, 32'h3F, 0));
    vecs.push_back(mk(1, 0, 32'h3F, 6'h00, 0, 0, 32'h3F, 0));
    vecs.push_back(mk(0, 0, 32'h00, 6'h12, 0, 1, 32'h12, 0));
    vecs.push_back(mk(0, 0, 32'h00, 6'h00, 0, 3, 32'h11, 1));
    vecs.push_back(mk(0, 0, 32'h00, 6'h00, 1, 1, 32'h10, 0));
    vecs.push_back(mk(1, 4, 32'h00, 6'h00, 0, 3, 32'h01, 0));
    vecs.push_back(mk(0, 0, 32'h00, 6'h00, 0, 3, 32'h14, 1));
    vecs.push_back(mk(0, 0, 32'h00, 6'h00, 1, 1, 32'h00, 0));
    vecs.push_back(mk(1, 4, 32'h00, 6'h00, 0, 3, 32'h04, 0));
    // Retract: level drop, then masking in REQ
    vecs.push_back(mk(1, 2, 32'h3E, 6'h00, 0, 2, 32'h3E, 0));
    vecs.push_back(mk(0, 0, 32'h00, 6'h01, 0, 3, 32'h10, 1));
    vecs.push_back(mk(0, 0, 32'h00, 6'h00, 0, 3, 32'h00, 0));
    vecs.push_back(mk(0, 0, 32'h00, 6'h00, 0, 3, 32'h00, 0));
    vecs.push_back(mk(0, 0, 32'h00, 6'h01, 0, 3, 32'h10, 1));
    vecs.push_back(mk(1, 0, 32'h3E, 6'h01, 0, 3, 32'h10, 1));
    vecs.push_back(mk(0, 0, 32'h00, 6'h01, 0, 3, 32'h00, 0));
    // Set/clear collision, stray ack and EOI
    vecs.push_back(mk(0, 0, 32'h00, 6'h00, 0, 1, 32'h00, 0));
    vecs.push_back(mk(1, 1, 32'h08, 6'h08, 0, 1, 32'h08, 0));
    vecs.push_back(mk(0, 0, 32'h00, 6'h08, 0, 3, 32'h13, 1));
    vecs.push_back(mk(1, 4, 32'h00, 6'h08, 0, 3, 32'h13, 1));
    vecs.push_back(mk(0, 0, 32'h00, 6'h00, 1, 3, 32'h23, 0));
    vecs.push_back(mk(0, 0, 32'h00, 6'h00, 1, 3, 32'h23, 0));
    vecs.push_back(mk(1, 4, 32'h00, 6'h00, 0, 3, 32'h03, 0));
    vecs.push_back(mk(0, 0, 32'h00, 6'h00, 1, 3, 32'h03, 0));
    // Switching an edge source to level drops its stored bit
    vecs.push_back(mk(0, 0, 32'h00, 6'h20, 0, 1, 32'h20, 0));
    vecs.push_back(mk(1, 2, 32'h1E, 6'h00, 0, 1, 32'h00, 1));
    vecs.push_back(mk(0, 0, 32'h00, 6'h00, 0, 3, 32'h05, 0));
    // Walk into SERVICE for the async-reset check
    vecs.push_back(mk(1, 2, 32'h00, 6'h04, 0, 3, 32'h05, 0));
    vecs.push_back(mk(0, 0, 32'h00, 6'h04, 0, 3, 32'h12, 1));
    vecs.push_back(mk(0, 0, 32'h00, 6'h04, 1, 3, 32'h22, 0));
    foreach (vecs[n]) applyVec(n, vecs[n]);

    // Async reset between edges while in SERVICE
    #1 reset = 1'b0;
    #1 chk("async.irq", {31'b0, irq}, 32'd0);
    addr = 3'd3; #1 chk("async.status", rd, 32'd0);
    addr = 3'd0; #1 chk("async.mask", rd, 32'd0);
    @(negedge clk) reset = 1'b1;
    src = '0;

    // Randomized run against the reference model
    @(negedge clk) reset = 1'b0;
    mReset();
    @(negedge clk) reset = 1'b1;
    for (int c = 0; c < 800; c++) begin
      bit          w, k;
      int          a;
      logic [31:0] d;
      @(negedge clk);
      w = ($urandom_range(0, 3) == 0);
      a = $urandom_range(0, 7);
      d = $urandom;
      k = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) src = 6'($urandom);
      we = w; addr = 3'(a); wd = d; ack = k;
      #2;
      chk($sformatf("rnd%0d.rd", c), rd, mRead(a, src));
      chk($sformatf("rnd%0d.irq", c), {31'b0, irq}, {31'b0, mIrq});
      @(posedge clk);
      mStep(w, a, d, src, k);
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/intc_ctrl.md
Name: intc_ctrl

Overview:
- Programmable interrupt controller between the device bridge's raw interrupt lines and the CPU's external-interrupt input.
- Captures six device interrupt sources and applies per-source mask and edge/level mode.
- Picks one source by fixed priority and runs a request/acknowledge/end-of-interrupt handshake with the CPU.
- Its registers sit on the bridge's device bus as one more memory-mapped device.

Parameters:
- NSRC, 6, number of interrupt sources (max 8; id fits 3 bits).
- MASK_RST, 6'b000000, reset value of MASK (all sources masked).
- MODE_RST, 6'b000000, reset value of MODE (all sources level).

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- we  in  1  register write strobe (bridge-decoded CPU store)
- addr  in  3  word offset, device address bits [4:2]
- wd  in  32  write data
- rd  out  32  read data, combinational from addr
- src  in  NSRC  raw device interrupt lines, synchronous to clk
- ack  in  1  one-cycle pulse: CPU has taken the interrupt
- irq  out  1  registered request to CPU (feeds HWint bit 0)

Behaviour:
- Registers (offset: name):
  - 0: MASK [NSRC-1:0], RW, 1 = enabled.
  - 1: PEND [NSRC-1:0], read = pending vector; write-1-to-clear edge bits.
  - 2: MODE [NSRC-1:0], RW, 1 = edge, 0 = level.
  - 3: STATUS, RO: [2:0] id, [5:4] state (IDLE=0, REQ=1, SERVICE=2).
  - 4: EOI, WO, any write ends service.
  - Unused bits and offsets 5-7 read 0; writes to them are ignored.
- Reset (async, reset=0):
  - MASK=MASK_RST, MODE=MODE_RST, edge pending=0, src_q=0, state=IDLE, id=0, irq=0.
  - Reset mid-request or mid-service returns to IDLE with irq=0 immediately.
- Pending:
  - Edge source: pend bit set at the edge where src=1 and src_q=0 (src_q = src delayed one cycle).
  - Edge source: pend bit cleared by a PEND W1C write, or by ack for the latched id.
  - If set and clear hit the same cycle, set wins.
  - Level source: pend = src live, not stored; W1C has no effect.
  - Changing MODE to level clears that source's stored edge bit.
- eligible = pend & MASK. Priority: lowest index wins.
- FSM:
  - IDLE: if eligible != 0, latch id = highest-priority eligible bit, go to REQ, irq <= 1.
  - REQ: irq held 1.
    - ack=1: go to SERVICE, irq <= 0, clear edge pend[id].
    - Else if eligible[id]=0 (masked, W1C'd, or level dropped): retract, go to IDLE, irq <= 0.
    - No preemption: a higher-priority arrival while in REQ does not change id.
  - SERVICE: irq=0. A write to EOI goes to IDLE. Pending/mask updates continue, but nothing is requested.
- ack outside REQ is ignored. EOI outside SERVICE is ignored.
- EOI and a new eligible source: IDLE is entered first, so the next REQ starts one cycle later. At least one IDLE cycle occurs between services.
- Latency from src first sampled high at edge E0:
  - Level: state=REQ, irq=1 after E0.
  - Edge: pend=1 after E0, irq=1 after E1.
- Register writes take effect at the clock edge. rd reflects post-edge state.

Test Plan:
- Reset: hold reset=0 with src=6'h3F -> irq=0; rd@0=0, @2=0, @3=0; release -> irq stays 0 (all masked).
- Level, single source: write MASK=6'h04; raise src[2] -> irq=1 after the same edge; STATUS=0x12. Pulse ack -> irq=0, STATUS=0x22. Write EOI with src[2] still high -> IDLE, then REQ again next edge.
- Edge, priority: MODE=6'h3F, MASK=6'h3F. Pulse src[4] and src[1] one cycle together -> PEND=6'h12, irq=1 two edges after, id=1. ack -> PEND=6'h10. EOI -> id=4 requested; ack clears PEND to 0.
- Retract: level src[0] enabled, irq=1; drop src[0] before ack -> irq=0 next edge, state=IDLE, no SERVICE. Masking in REQ does the same.
- Set/clear collision: edge src[3] rises on the same edge as a PEND write of 6'h08 -> PEND[3]=1. Stray ack in IDLE and EOI in REQ leave state unchanged.
- Async reset in SERVICE: state=2, assert reset between clock edges -> irq=0, STATUS=0, MASK=0 without waiting for clk.
